// File: rtl/jpeg_pkg.sv
// -----------------------------------------------------------------------------
// jpeg_pkg
//   Shared definitions for the JPEG block-row datapath: block geometry, pixel
//   width, the row accumulator state type and a one-bit full-adder cell used
//   by the ripple adder.
// -----------------------------------------------------------------------------
package jpeg_pkg;

   // Samples per block row and width of one unsigned pixel sample.
   localparam int BLOCK_DIM = 8;
   localparam int PIXEL_W   = 8;

   // Row accumulator states: collecting samples, or presenting a finished sum.
   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } row_state_t;

   // One-bit full-adder cell; returns {carry_out, sum}.
   function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic cin);
      logic sum_bit;
      logic carry_bit;
      sum_bit   = a ^ b ^ cin;
      carry_bit = (a & b) | (a & cin) | (b & cin);
      return {carry_bit, sum_bit};
   endfunction

endpackage : jpeg_pkg

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//   Unsigned WIDTH-bit ripple-carry adder built from one-bit full-adder cells.
//   The result is WIDTH+1 bits wide; bit WIDTH is the carry-out.
// Ports
//   a  in   WIDTH    first operand
//   b  in   WIDTH    second operand
//   s  out  WIDTH+1  {carry_out, sum}
// -----------------------------------------------------------------------------
module full_adder
   import jpeg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   s
);

   logic             carry_v;
   logic [WIDTH-1:0] sum_v;
   logic [1:0]       cell_v;

   // Ripple the carry through the cells; the carry is a procedural variable so
   // the chain is evaluated in order within a single block.
   always_comb begin
      carry_v = 1'b0;
      sum_v   = '0;
      cell_v  = 2'b00;
      for (int i = 0; i < WIDTH; i++) begin
         cell_v   = fa_cell(a[i], b[i], carry_v);
         sum_v[i] = cell_v[0];
         carry_v  = cell_v[1];
      end
      s = {carry_v, sum_v};
   end

endmodule : full_adder

// File: rtl/row_sum_accumulator.sv
// -----------------------------------------------------------------------------
// row_sum_accumulator
//   Sums N consecutive unsigned samples (one block row) into a width-grown
//   result. The running total and each accepted sample feed a full_adder
//   every cycle. After the Nth accepted sample the sum is presented on the
//   output until downstream accepts it; no samples are taken meanwhile.
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   in_data    in   WIDTH  sample value (unsigned)
//   in_valid   in   1      in_data valid this cycle
//   in_ready   out  1      a sample is accepted this cycle when in_valid is high
//   out_sum    out  SUM_W  completed row sum
//   out_valid  out  1      out_sum valid; held until accepted
//   out_ready  in   1      downstream accepts out_sum this cycle
//   busy       out  1      a partial row is in progress
// -----------------------------------------------------------------------------
module row_sum_accumulator
   import jpeg_pkg::*;
#(
   parameter int WIDTH = PIXEL_W,
   parameter int N     = BLOCK_DIM,
   localparam int SUM_W = WIDTH + $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(N);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

   row_state_t       state_r;
   logic [SUM_W-1:0] acc_r;
   logic [CNT_W-1:0] count_r;
   logic [SUM_W-1:0] out_sum_r;
   logic             out_valid_r;

   logic [SUM_W-1:0] sample_ext_s;
   logic [SUM_W:0]   sum_s;
   logic             in_hs_s;
   logic             out_hs_s;
   logic             unused_carry_s;

   // Zero-extend the sample to the accumulator width.
   assign sample_ext_s = {{(SUM_W - WIDTH){1'b0}}, in_data};

   full_adder #(
      .WIDTH (SUM_W)
   ) u_full_adder (
      .a (acc_r),
      .b (sample_ext_s),
      .s (sum_s)
   );

   // SUM_W is sized so N maximal samples cannot overflow; the carry is always 0.
   assign unused_carry_s = sum_s[SUM_W];

   // in_ready is gated by rst so it reads 0 during reset and 1 right after it.
   assign in_ready  = (state_r == ACCUM) && !rst;
   assign in_hs_s   = in_valid && in_ready;
   assign out_hs_s  = out_valid_r && out_ready;

   assign out_sum   = out_sum_r;
   assign out_valid = out_valid_r;
   assign busy      = (count_r != '0);

   // Row FSM: accumulate N accepted samples, then hold the sum until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ACCUM;
         acc_r       <= '0;
         count_r     <= '0;
         out_sum_r   <= '0;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ACCUM: begin
               if (in_hs_s) begin
                  if (count_r == LAST_IDX) begin
                     // Last sample of the row: publish and start a fresh row.
                     out_sum_r   <= sum_s[SUM_W-1:0];
                     out_valid_r <= 1'b1;
                     acc_r       <= '0;
                     count_r     <= '0;
                     state_r     <= HOLD;
                  end else begin
                     acc_r   <= sum_s[SUM_W-1:0];
                     count_r <= count_r + CNT_W'(1);
                  end
               end else begin
                  acc_r   <= acc_r;
                  count_r <= count_r;
               end
            end
            HOLD: begin
               if (out_hs_s) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ACCUM;
               end else begin
                  out_valid_r <= out_valid_r;
                  state_r     <= HOLD;
               end
            end
            default: begin
               // Unreachable encoding: recover to a clean, idle row.
               state_r     <= ACCUM;
               acc_r       <= '0;
               count_r     <= '0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule : row_sum_accumulator
